// File: rtl/ntt_seq_ctrl.sv
// ntt_seq_ctrl: run sequencer for an N-point Gentleman-Sande NTT.
// A run loads N coefficients, issues LOGN butterfly stages with a
// BF_LAT-cycle drain after each one, then streams the buffer out.
// Optional build macro NTT_SEQ_CTRL_BITREV_EN: the unload phase reads
// in bit-reversed address order, so the output stream comes out in
// natural order. When the macro is undefined, the buffer is read
// linearly and the output is in raw DIF (bit-reversed) order.
module ntt_seq_ctrl #(
  parameter int N      = 8,
  parameter int LOGN   = $clog2(N),
  parameter int BF_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr,
  output logic            bf_valid,
  output logic [LOGN-1:0] bf_addr_a,
  output logic [LOGN-1:0] bf_addr_b,
  output logic [LOGN-2:0] bf_tw_idx,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr,
  output logic            out_valid,
  output logic            busy,
  output logic            done
);

  localparam int CW   = LOGN + 1;
  localparam int HALF = N / 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_UNLOAD, S_DONE
  } state_t;

  state_t state, state_nx;

  // cnt is shared by the load, issue and unload phases. It has one spare
  // MSB so that the unload phase can run one extra cycle (cnt == N). That
  // extra cycle waits for the last out_valid before DONE.
  logic [CW-1:0]   cnt;
  logic [LOGN-1:0] stg;
  logic [3:0]      dcnt;

  logic last_ld, last_bf, drain_end, last_stg;
  assign last_ld   = (cnt == CW'(N - 1));
  assign last_bf   = (cnt == CW'(HALF - 1));
  assign drain_end = (dcnt == 4'(BF_LAT - 1));
  assign last_stg  = (stg == LOGN'(LOGN - 1));

  // Butterfly index math for stage stg, butterfly j.
  // addr_a keeps the low log2(span) bits of j and shifts the rest up by
  // one. This equals (j/span)*2*span + j%span. addr_b is addr_a + span.
  logic [LOGN-1:0] span, mask, jl, addr_a, addr_b;
  logic [LOGN-2:0] tw;

  // Compute operand addresses and twiddle index from the stage and j.
  always_comb begin
    span   = LOGN'(N >> (int'(stg) + 1));
    mask   = span - LOGN'(1);
    jl     = LOGN'(cnt[LOGN-2:0]);
    addr_a = ((jl & ~mask) << 1) | (jl & mask);
    addr_b = addr_a + span;
    tw     = (LOGN-1)'(jl & mask) << stg;
  end

  // Unload read index, optionally bit-reversed.
  logic [LOGN-1:0] rd_idx;
`ifdef NTT_SEQ_CTRL_BITREV_EN
  for (genvar i = 0; i < LOGN; i++) begin : g_rev
    assign rd_idx[i] = cnt[LOGN-1-i];
  end
`else
  assign rd_idx = cnt[LOGN-1:0];
`endif

  // State register. The async reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= state_nx;

  // Next-state logic and phase strobes.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    wr_en    = 1'b0;
    bf_valid = 1'b0;
    rd_en    = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        wr_en    = in_valid;
        if (in_valid && last_ld) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        bf_valid = 1'b1;
        if (last_bf) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_end) state_nx = last_stg ? S_UNLOAD : S_ISSUE;
      end
      S_UNLOAD: begin
        rd_en = ~cnt[LOGN];
        if (cnt[LOGN]) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Phase counters. Each phase leaves cnt at 0 for the next phase.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt  <= '0;
      stg  <= '0;
      dcnt <= '0;
    end else begin
      case (state)
        S_LOAD:
          if (in_valid) cnt <= last_ld ? '0 : cnt + CW'(1);
        S_ISSUE: begin
          cnt  <= last_bf ? '0 : cnt + CW'(1);
          dcnt <= '0;
        end
        S_DRAIN: begin
          dcnt <= dcnt + 4'd1;
          if (drain_end) begin
            dcnt <= '0;
            if (!last_stg) stg <= stg + LOGN'(1);
          end
        end
        S_UNLOAD: cnt <= cnt + CW'(1);
        default: begin
          cnt  <= '0;
          stg  <= '0;
          dcnt <= '0;
        end
      endcase
    end

  // Hold registers. Each address output tracks its counter while its
  // strobe is high, and keeps the last issued value otherwise.
  logic [LOGN-1:0] wr_q, a_q, b_q, rd_q;
  logic [LOGN-2:0] tw_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      tw_q      <= '0;
      rd_q      <= '0;
      out_valid <= 1'b0;
    end else begin
      if (wr_en) wr_q <= cnt[LOGN-1:0];
      if (bf_valid) begin
        a_q  <= addr_a;
        b_q  <= addr_b;
        tw_q <= tw;
      end
      if (rd_en) rd_q <= rd_idx;
      out_valid <= rd_en;
    end

  assign wr_addr   = wr_en    ? cnt[LOGN-1:0] : wr_q;
  assign bf_addr_a = bf_valid ? addr_a        : a_q;
  assign bf_addr_b = bf_valid ? addr_b        : b_q;
  assign bf_tw_idx = bf_valid ? tw            : tw_q;
  assign rd_addr   = rd_en    ? rd_idx        : rd_q;

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// tb_ntt_seq_ctrl: two instances, BF_LAT = 4 and BF_LAT = 1, share the
// stimulus. Each run is checked against a reference model built from the
// run-phase arithmetic: load handshakes, the butterfly formulas, the
// phase start cycles and the unload order.
module tb_ntt_seq_ctrl;
  localparam int N = 8, LOGN = 3, HALF = 4;

  logic clk = 1'b0;
  logic rst, start, in_valid;
  always #5 clk = ~clk;

  logic [1:0]            in_ready, wr_en, bf_valid, rd_en, out_valid, busy, done;
  logic [1:0][LOGN-1:0]  wr_addr, bf_addr_a, bf_addr_b, rd_addr;
  logic [1:0][LOGN-2:0]  bf_tw_idx;
  logic [1:0][31:0]      vec;

  ntt_seq_ctrl #(.N(N), .BF_LAT(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
    .bf_valid(bf_valid[0]), .bf_addr_a(bf_addr_a[0]), .bf_addr_b(bf_addr_b[0]),
    .bf_tw_idx(bf_tw_idx[0]), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
    .out_valid(out_valid[0]), .busy(busy[0]), .done(done[0]));

  ntt_seq_ctrl #(.N(N), .BF_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
    .bf_valid(bf_valid[1]), .bf_addr_a(bf_addr_a[1]), .bf_addr_b(bf_addr_b[1]),
    .bf_tw_idx(bf_tw_idx[1]), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]),
    .out_valid(out_valid[1]), .busy(busy[1]), .done(done[1]));

  for (genvar d = 0; d < 2; d++) begin : g_vec
    assign vec[d] = 32'({in_ready[d], wr_en[d], wr_addr[d], bf_valid[d],
                         bf_addr_a[d], bf_addr_b[d], bf_tw_idx[d], rd_en[d],
                         rd_addr[d], out_valid[d], busy[d], done[d]});
  end

  int total = 0, bad = 0;

  // Per-run capture, indexed by instance.
  int bf_a[2][64], bf_b[2][64], bf_t[2][64], bf_c[2][64];
  int rd_a[2][32], rd_c[2][32];
  int bf_n[2], rd_n[2], ov_n[2], ov_first[2], done_n[2], done_c[2], busy_n[2];

  function automatic int bl(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int exp_rd(input int k);
    int r;
    r = k;
`ifdef NTT_SEQ_CTRL_BITREV_EN
    r = 0;
    for (int i = 0; i < LOGN; i++)
      if ((k >> i) % 2 == 1) r += 1 << (LOGN - 1 - i);
`endif
    return r;
  endfunction

  // mode: 0 continuous in_valid, 1 drop 3 cycles after 5th coefficient,
  //       2 random in_valid, 3 continuous plus stray start pulses mid-run.
  // abort_at > 0 asserts rst in that cycle and ends the run there.
  task automatic do_run(input int mode, input int abort_at, input string nm);
    int mk, stall, sc, lim, s, j, span, ea, eb, et, ec, base, cs, rs, elat;
    bit iv, hs, ld;
    mk = 0; stall = 0; sc = 0;
    for (int d = 0; d < 2; d++) begin
      bf_n[d] = 0; rd_n[d] = 0; ov_n[d] = 0; ov_first[d] = -1;
      done_n[d] = 0; done_c[d] = -1; busy_n[d] = 0;
    end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      start = (c == 0) || (mode == 3 && (c == 5 || c == 20));
      ld = (c >= 1 && mk < N);
      case (mode)
        1: begin
          iv = !(ld && mk == 5 && sc < 3);
          if (!iv) sc++;
        end
        2: iv = ($urandom_range(0, 2) != 0);
        default: iv = 1'b1;
      endcase
      in_valid = iv;
      if (abort_at > 0 && c == abort_at) begin
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
          total++;
          if (vec[d] !== 32'd0) begin
            bad++;
            $display("FAIL %s abort_outputs dut%0d: got %h want 0", nm, d, vec[d]);
          end
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        return;
      end
      #1;
      hs = ld && iv;
      for (int d = 0; d < 2; d++) begin
        total++;
        if (in_ready[d] !== ld || wr_en[d] !== hs || (hs && wr_addr[d] !== LOGN'(mk))) begin
          bad++;
          $display("FAIL %s load c%0d dut%0d: got rdy=%b we=%b wa=%0d want rdy=%b we=%b wa=%0d",
                   nm, c, d, in_ready[d], wr_en[d], wr_addr[d], ld, hs, mk);
        end
        if (bf_valid[d] === 1'b1 && bf_n[d] < 64) begin
          bf_a[d][bf_n[d]] = int'(bf_addr_a[d]);
          bf_b[d][bf_n[d]] = int'(bf_addr_b[d]);
          bf_t[d][bf_n[d]] = int'(bf_tw_idx[d]);
          bf_c[d][bf_n[d]] = c;
          bf_n[d]++;
        end
        if (rd_en[d] === 1'b1 && rd_n[d] < 32) begin
          rd_a[d][rd_n[d]] = int'(rd_addr[d]);
          rd_c[d][rd_n[d]] = c;
          rd_n[d]++;
        end
        if (out_valid[d] === 1'b1) begin
          if (ov_first[d] < 0) ov_first[d] = c;
          ov_n[d]++;
        end
        if (done[d] === 1'b1) begin
          done_n[d]++;
          done_c[d] = c;
        end
        if (busy[d] === 1'b1) busy_n[d]++;
      end
      if (ld) begin
        if (iv) mk++;
        else stall++;
      end
      lim = (done_c[0] > done_c[1]) ? done_c[0] : done_c[1];
      if (done_c[0] >= 0 && done_c[1] >= 0 && c >= lim + 2) break;
    end
    start = 1'b0;

    // Compare the capture against the model for each instance.
    for (int d = 0; d < 2; d++) begin
      base = N + 1 + stall;
      cs   = HALF + bl(d);
      rs   = base + LOGN * cs;
      elat = 1 + N + stall + LOGN * cs + N + 1 + 1;
      total++;
      if (bf_n[d] != LOGN * HALF) begin
        bad++;
        $display("FAIL %s bf_count dut%0d: got %0d want %0d", nm, d, bf_n[d], LOGN * HALF);
      end
      for (int k = 0; k < bf_n[d] && k < LOGN * HALF; k++) begin
        s = k / HALF; j = k % HALF; span = N >> (s + 1);
        ea = (j / span) * 2 * span + (j % span);
        eb = ea + span;
        et = (j % span) << s;
        ec = base + s * cs + j;
        total++;
        if (bf_a[d][k] != ea || bf_b[d][k] != eb || bf_t[d][k] != et) begin
          bad++;
          $display("FAIL %s bf_pair dut%0d s%0d j%0d: got (%0d,%0d,tw%0d) want (%0d,%0d,tw%0d)",
                   nm, d, s, j, bf_a[d][k], bf_b[d][k], bf_t[d][k], ea, eb, et);
        end
        total++;
        if (bf_c[d][k] != ec) begin
          bad++;
          $display("FAIL %s bf_timing dut%0d s%0d j%0d: got c%0d want c%0d",
                   nm, d, s, j, bf_c[d][k], ec);
        end
        if (j == 0 && s > 0) begin
          total++;
          if (bf_c[d][k] - bf_c[d][k-1] - 1 != bl(d)) begin
            bad++;
            $display("FAIL %s drain_gap dut%0d s%0d: got %0d want %0d",
                     nm, d, s, bf_c[d][k] - bf_c[d][k-1] - 1, bl(d));
          end
        end
      end
      total++;
      if (rd_n[d] != N) begin
        bad++;
        $display("FAIL %s rd_count dut%0d: got %0d want %0d", nm, d, rd_n[d], N);
      end
      for (int k = 0; k < rd_n[d] && k < N; k++) begin
        total++;
        if (rd_a[d][k] != exp_rd(k) || rd_c[d][k] != rs + k) begin
          bad++;
          $display("FAIL %s rd_addr dut%0d k%0d: got %0d@c%0d want %0d@c%0d",
                   nm, d, k, rd_a[d][k], rd_c[d][k], exp_rd(k), rs + k);
        end
      end
      total++;
      if (ov_n[d] != N || ov_first[d] != rs + 1) begin
        bad++;
        $display("FAIL %s out_valid dut%0d: got %0d cycles from c%0d want %0d from c%0d",
                 nm, d, ov_n[d], ov_first[d], N, rs + 1);
      end
      total++;
      if (done_n[d] != 1 || done_c[d] + 1 != elat) begin
        bad++;
        $display("FAIL %s latency dut%0d: got %0d pulses, %0d cycles want 1, %0d",
                 nm, d, done_n[d], done_c[d] + 1, elat);
      end
      total++;
      if (busy_n[d] != elat - 1) begin
        bad++;
        $display("FAIL %s busy dut%0d: got %0d cycles want %0d", nm, d, busy_n[d], elat - 1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      #1;
      for (int d = 0; d < 2; d++) begin
        total++;
        if (vec[d] !== 32'd0) begin
          bad++;
          $display("FAIL reset_idle c%0d dut%0d: got %h want 0", c, d, vec[d]);
        end
      end
    end
  endtask

  task automatic test_full_run();
    do_run(0, 0, "full_run");
  endtask

  task automatic test_stalled_load();
    do_run(1, 0, "stalled_load");
  endtask

  task automatic test_random_stall();
    for (int r = 0; r < 3; r++) do_run(2, 0, "random_stall");
  endtask

  // Abort during stage 1 of the BF_LAT=4 instance, then run cleanly with
  // stray start pulses that must be ignored.
  task automatic test_abort();
    do_run(0, N + 1 + (HALF + 4) + 1, "abort");
    do_run(3, 0, "after_abort");
  endtask

  task automatic test_back_to_back();
    do_run(2, 0, "back_to_back_a");
    do_run(0, 0, "back_to_back_b");
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_stalled_load();
    test_random_stall();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
